sysx_slave_port: RTL
====================

# sysx_slave_port

Peripheral-side endpoint of the sysX bus: the responder that sits opposite the sysX master controller. It watches the 2-bit select, bus clock and 8-bit MOSI lanes, decodes command/data frames, and turns them into single-cycle register-write and register-read strobes on a local peripheral register interface. It returns read data MSB-first on the 8-bit MISO lane and forwards a local interrupt request to the master. Bus signals are asynchronous to iClk and are oversampled.

## Interface
- pSelectID, 2'h1, select code this endpoint answers to; must be nonzero because 2'h0 means bus idle
- iClk  in  1  peripheral system clock; all logic is on the rising edge
- iReset  in  1  synchronous, active-high reset
- iBusClock  in  1  sysX bus clock from the master; held 0 while idle
- iBusSelect  in  2  sysX chip select code
- iBusMOSI  in  8  master-to-slave byte lane
- oBusMISO  out  8  slave-to-master byte lane; driven at all times, with no tri-state
- oBusInterrupt  out  1  registered copy of iIrq
- iIrq  in  1  level interrupt request from the peripheral
- oRegAddr  out  7  local register address
- oRegWrData  out  32  local write data
- oRegWrite  out  1  one-cycle write strobe
- oRegRead  out  1  one-cycle read strobe
- iRegRdData  in  32  read data, valid the iClk cycle after oRegRead
- oBusy  out  1  high while a frame is in progress (state other than IDLE)

## Operation
- Synchronizer:
  - iBusClock, iBusSelect and iBusMOSI each pass through 2 flops.
  - A third flop on the synchronized clock gives the rise and fall edge pulses.
- Selected: the synchronized select equals pSelectID.
- Frame byte 0 is the command byte:
  - bit7 is the direction: 1 = write, 0 = read.
  - bits[6:0] are the register address.
- Write frame:
  - Frame is the command byte plus 4 data bytes, bits 31:24 first.
  - Each byte is sampled on a bus-clock rise.
- Read frame:
  - Frame is the command byte plus 4 response bytes, bits 31:24 first.
  - The slave drives each response byte on a bus-clock fall.
  - The master samples each response byte on the following rise.
- States and transitions:
  - IDLE → CMD when selected.
  - CMD, on a rise: latch the byte into oRegAddr and the direction flag.
    - Write direction: go to WDATA.
    - Read direction: pulse oRegRead, capture iRegRdData into the shift register on the next iClk, go to RDATA.
  - WDATA, on each rise: shift the MOSI byte into oRegWrData and increment the 2-bit byte count.
    - On the 4th byte, pulse oRegWrite and go to DONE.
  - RDATA, on each fall: present the next shift-register byte on oBusMISO.
    - After the 4th byte is presented, go to DONE on the next rise.
  - DONE: extra rises are ignored and oBusMISO = 8'hFF. Return to IDLE when deselected.
  - Any state other than IDLE: deselect returns to IDLE immediately and clears the byte count.
    - A partial write never strobes oRegWrite.
- oBusMISO values by state:
  - 8'h00 in IDLE, CMD and WDATA.
  - Shift-register byte in RDATA.
  - 8'hFF in DONE.
- oRegAddr and oRegWrData hold their values between frames.

## Timing
- Reset values:
  - State IDLE.
  - oBusMISO 8'h00.
  - oRegAddr 0, oRegWrData 0.
  - oRegWrite 0, oRegRead 0.
  - oBusy 0, oBusInterrupt 0.
  - Synchronizer flops 0.
- Reset mid-frame aborts the frame with no strobe.
- Bus-clock edge to internal edge pulse: 3 iClk.
- Bus-clock high time and low time must each be at least 4 iClk; the master's clock divider must guarantee this.
- oRegWrite: asserted 1 iClk after the rise pulse of the 4th data byte, for exactly 1 cycle.
  - oRegWrData is stable in the same cycle.
- oRegRead: asserted 1 iClk after the command-byte rise pulse, for 1 cycle.
  - iRegRdData is sampled on the following cycle.
  - Read data is ready well before the first fall pulse.
- oBusMISO changes 1 iClk after a fall pulse, so it is stable for the full high-to-low window before the next rise.
- Select change coincident with an edge pulse: deselect wins and the edge is ignored.
- oBusInterrupt = iIrq delayed by 1 iClk. It is independent of the frame state.

## Test plan
- Write frame:
  - Stimulus: select=1, bytes 8'h85, 8'hDE, 8'hAD, 8'hBE, 8'hEF.
  - Required: exactly one oRegWrite pulse with oRegAddr=7'h05 and oRegWrData=32'hDEADBEEF; oBusMISO=8'h00 throughout, then 8'hFF in DONE.
- Read frame:
  - Stimulus: command 8'h12 with iRegRdData=32'h0BADC0DE.
  - Required: one oRegRead pulse with oRegAddr=7'h12; MISO sampled at the next 4 rises reads 8'h0B, 8'hAD, 8'hC0, 8'hDE.
- Abort:
  - Stimulus: deselect after the command byte plus 2 write bytes.
  - Required: no oRegWrite, state IDLE, and the next full frame works normally.
- Wrong select:
  - Stimulus: a full write frame with select=2'h2 against pSelectID=1.
  - Required: no strobes, oBusy stays 0, oBusMISO stays 8'h00.
- Reset:
  - Stimulus: iReset asserted during RDATA byte 2.
  - Required: all outputs at their reset values the next cycle; a new read frame returns the correct data.
- Interrupt and overrun:
  - Stimulus: toggle iIrq; send 7 bytes in one write frame.
  - Required: oBusInterrupt follows iIrq 1 cycle late; exactly one oRegWrite; MISO=8'hFF for bytes 6 and 7.

Source files
------------

// File: rtl/sysx_slave_port.sv
// ---------------------------------------------------------------------------
// sysx_slave_port
//
// Peripheral-side endpoint of the sysX bus. The master drives a 2-bit select
// code, a bus clock and an 8-bit MOSI lane; this block oversamples all of them
// on iClk, decodes command/data frames and converts them into single-cycle
// register strobes on the local peripheral register interface. Read data goes
// back MSB byte first on the 8-bit MISO lane. The peripheral interrupt request
// is forwarded to the master with one register stage.
//
// Frame format (one byte per bus-clock rise):
//   byte 0      : command, bit7 = 1 write / 0 read, bits[6:0] register address
//   bytes 1..4  : write data (bits 31:24 first) or read response slots
//
// Ports
//   pSelectID      parameter, select code this endpoint answers to (nonzero)
//   iClk           peripheral system clock, rising edge
//   iReset         synchronous active-high reset
//   iBusClock      sysX bus clock from the master (0 while idle)
//   iBusSelect     sysX chip select code, 2'h0 = bus idle
//   iBusMOSI       master-to-slave byte lane
//   oBusMISO       slave-to-master byte lane, always driven
//   oBusInterrupt  iIrq delayed by one iClk
//   iIrq           level interrupt request from the peripheral
//   oRegAddr       local register address (holds between frames)
//   oRegWrData     local write data (holds between frames)
//   oRegWrite      one-cycle write strobe
//   oRegRead       one-cycle read strobe
//   iRegRdData     read data, valid the iClk cycle after oRegRead
//   oBusy          high while a frame is in progress
// ---------------------------------------------------------------------------
module sysx_slave_port #(
    parameter logic [1:0] pSelectID = 2'h1
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [1:0]  iBusSelect,
    input  logic [7:0]  iBusMOSI,
    output logic [7:0]  oBusMISO,
    output logic        oBusInterrupt,
    input  logic        iIrq,
    output logic [6:0]  oRegAddr,
    output logic [31:0] oRegWrData,
    output logic        oRegWrite,
    output logic        oRegRead,
    input  logic [31:0] iRegRdData,
    output logic        oBusy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT       state;
    stateT       nextState;

    logic        busClkS1;
    logic        busClkS2;
    logic        busClkS3;
    logic [1:0]  selS1;
    logic [1:0]  selS2;
    logic [7:0]  mosiS1;
    logic [7:0]  mosiS2;

    logic        busRise;
    logic        busFall;
    logic        selected;

    logic [1:0]  byteCount;
    logic        lastPresented;
    logic        isWrite;
    logic        captureNext;
    logic [31:0] shiftReg;
    logic [7:0]  misoByte;

    logic        doWrite;
    logic        doRead;

    // The bus lines come from another clock domain, so every one of them goes
    // through a two-flop synchronizer. The bus clock gets a third flop so that
    // its edges can be detected by comparing the last two synchronized samples.
    // MOSI is only ever sampled on a bus-clock rise, long after the master set
    // it up, so a multi-bit synchronizer is safe for that lane.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            busClkS1 <= 1'b0;
            busClkS2 <= 1'b0;
            busClkS3 <= 1'b0;
            selS1    <= 2'h0;
            selS2    <= 2'h0;
            mosiS1   <= 8'h00;
            mosiS2   <= 8'h00;
        end else begin
            busClkS1 <= iBusClock;
            busClkS2 <= busClkS1;
            busClkS3 <= busClkS2;
            selS1    <= iBusSelect;
            selS2    <= selS1;
            mosiS1   <= iBusMOSI;
            mosiS2   <= mosiS1;
        end
    end

    assign busRise  = busClkS2 & ~busClkS3;
    assign busFall  = ~busClkS2 & busClkS3;
    assign selected = (selS2 == pSelectID);

    // Strobe conditions. Both require the select to still be valid, which is
    // what makes a deselect win over a coincident edge pulse.
    assign doWrite = (state == WDATA) && selected && busRise && isWrite
                     && (byteCount == 2'd3);
    assign doRead  = (state == CMD) && selected && busRise && !mosiS2[7];

    // State register for the frame FSM.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Losing the select from any active state drops straight
    // back to IDLE, so an aborted frame never reaches a strobe.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (selected) begin
                    nextState = CMD;
                end
            end
            CMD: begin
                if (!selected) begin
                    nextState = IDLE;
                end else if (busRise) begin
                    nextState = mosiS2[7] ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (!selected) begin
                    nextState = IDLE;
                end else if (doWrite) begin
                    nextState = DONE;
                end
            end
            RDATA: begin
                if (!selected) begin
                    nextState = IDLE;
                end else if (busRise && lastPresented) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (!selected) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output decode from the state. In RDATA the MISO lane shows whatever
    // byte the last fall pulse presented; DONE answers 8'hFF so a master that
    // clocks past the end of a frame sees an obviously invalid byte.
    always_comb begin
        oBusy    = (state != IDLE);
        oBusMISO = 8'h00;
        case (state)
            RDATA:   oBusMISO = misoByte;
            DONE:    oBusMISO = 8'hFF;
            default: oBusMISO = 8'h00;
        endcase
    end

    // Frame datapath: command latch, write-data shifter, read-data shifter
    // and the registered strobes. The read capture lands two iClk after the
    // read strobe rises: the peripheral presents its data in the cycle after
    // oRegRead, and captureNext marks that cycle. With a bus-clock high time
    // of at least 4 iClk this is always done before the first fall pulse.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oRegAddr      <= 7'h00;
            oRegWrData    <= 32'h0000_0000;
            oRegWrite     <= 1'b0;
            oRegRead      <= 1'b0;
            oBusInterrupt <= 1'b0;
            byteCount     <= 2'd0;
            lastPresented <= 1'b0;
            isWrite       <= 1'b0;
            captureNext   <= 1'b0;
            shiftReg      <= 32'h0000_0000;
            misoByte      <= 8'h00;
        end else begin
            oRegWrite     <= doWrite;
            oRegRead      <= doRead;
            captureNext   <= oRegRead;
            oBusInterrupt <= iIrq;

            if (captureNext) begin
                shiftReg <= iRegRdData;
            end

            if (!selected || state == IDLE) begin
                byteCount     <= 2'd0;
                lastPresented <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (busRise) begin
                            oRegAddr      <= mosiS2[6:0];
                            isWrite       <= mosiS2[7];
                            byteCount     <= 2'd0;
                            lastPresented <= 1'b0;
                            misoByte      <= 8'h00;
                        end
                    end
                    WDATA: begin
                        if (busRise) begin
                            oRegWrData <= {oRegWrData[23:0], mosiS2};
                            byteCount  <= byteCount + 2'd1;
                        end
                    end
                    RDATA: begin
                        if (busFall && !lastPresented) begin
                            misoByte  <= shiftReg[31:24];
                            shiftReg  <= {shiftReg[23:0], 8'h00};
                            byteCount <= byteCount + 2'd1;
                            if (byteCount == 2'd3) begin
                                lastPresented <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
